unidade_controle_jogo: RTL and testbench

Moore control unit that sequences the memory-game datapath (round counter, play counter, button register, sequence RAM, timeout and display timers, RGB LED path). It registers the game configuration, shows the stored sequence one item per display interval, checks the player's presses against memory, and appends a new item after each completed round. It raises a win, loss or timeout result and then waits for a new start.

---
 rtl/unidade_controle_jogo.sv | 243 ++++++++++++++++++++++++
 tb/tb_unidade_controle_jogo.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// unidade_controle_jogo
//
// Moore control unit for the memory-game datapath. It registers the game
// configuration and writes the first (red) item. It shows the stored sequence
// one item per display interval, then checks the player's presses against
// memory. After each completed round it appends the item the player enters.
// The game ends in a win, loss or timeout state, and the unit then waits for
// a new start request.
//
// Optional feature macro: CONTROLE_TIMEOUT_EN
//   defined   -> the timeout counter runs in espera / espera_escrita, and
//                fimTimeout & configTimeout_reg ends the game in fim_timeout.
//   undefined -> contaTimeout and timeout are always 0. The FSM waits for a
//                play indefinitely.
//
// Ports
//   clock, reset            system clock; synchronous active-high reset
//   iniciar                 start request (level)
//   fimRodada, fimTotal,    datapath status: end of round / end of game,
//   igual, jogada_feita,    press matches memory, press edge pulse,
//   fimExibicao,            display interval elapsed,
//   fimTimeout,             timeout interval elapsed,
//   configTimeout_reg       registered timeout-enable from configuration
//   zeraCL .. registraR     counter / register / RAM controls
//   contaTimeout .. resetEdgeDetector   timer and edge-detector controls
//   seletorLedsBM           LED source (1 = memory, 0 = buttons)
//   mostraLeds              LED enable
//   botoes_fixo             RAM write source (1 = fixed red)
//   pronto, ganhou, perdeu, timeout     game result flags
//   db_estado               current state code
// -----------------------------------------------------------------------------
module unidade_controle_jogo (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       fimRodada,
  input  logic       fimTotal,
  input  logic       igual,
  input  logic       jogada_feita,
  input  logic       fimExibicao,
  input  logic       fimTimeout,
  input  logic       configTimeout_reg,
  output logic       zeraCL,
  output logic       contaCL,
  output logic       registraModo,
  output logic       zeraC,
  output logic       contaC,
  output logic       escreve,
  output logic       zeraR,
  output logic       registraR,
  output logic       contaTimeout,
  output logic       zeraTimeout,
  output logic       contaExibicao,
  output logic       zeraExibicao,
  output logic       resetEdgeDetector,
  output logic       seletorLedsBM,
  output logic       mostraLeds,
  output logic       botoes_fixo,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic [4:0] db_estado
);

`ifdef CONTROLE_TIMEOUT_EN
  localparam logic TimeoutEn = 1'b1;
`else
  localparam logic TimeoutEn = 1'b0;
`endif

  typedef enum logic [4:0] {
    estInicial        = 5'h00,
    estPreparacao     = 5'h01,
    estEscreveInicial = 5'h02,
    estInicioRodada   = 5'h03,
    estMostra         = 5'h04,
    estProximoMostra  = 5'h05,
    estFimMostra      = 5'h06,
    estEspera         = 5'h07,
    estRegistra       = 5'h08,
    estCompara        = 5'h09,
    estProximaJogada  = 5'h0A,
    estAvancaEscrita  = 5'h0B,
    estEsperaEscrita  = 5'h0C,
    estEscreveJogada  = 5'h0D,
    estProximaRodada  = 5'h0E,
    estFimAcertou     = 5'h10,
    estFimErrou       = 5'h11,
    estFimTimeout     = 5'h12
  } estado_t;

  estado_t estadoAtual;
  estado_t proximoEstado;
  logic    timeoutCond;

  // When the feature is compiled out, the timeout condition folds to a constant 0.
  assign timeoutCond = TimeoutEn & fimTimeout & configTimeout_reg;

  // State register
  always_ff @(posedge clock) begin
    // NOTE: state flops use non-blocking assignment so every flop samples
    // pre-edge values, independent of the order in which processes are evaluated.
    if (reset) estadoAtual <= estInicial;
    else       estadoAtual <= proximoEstado;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first, so no path through the case leaves the signal
    // unassigned (which would infer a latch).
    proximoEstado = estInicial;
    unique case (estadoAtual)
      estInicial:        proximoEstado = iniciar ? estPreparacao : estInicial;
      estPreparacao:     proximoEstado = estEscreveInicial;
      estEscreveInicial: proximoEstado = estInicioRodada;
      estInicioRodada:   proximoEstado = estMostra;
      estMostra: begin
        if (fimExibicao) proximoEstado = fimRodada ? estFimMostra : estProximoMostra;
        else             proximoEstado = estMostra;
      end
      estProximoMostra:  proximoEstado = estMostra;
      estFimMostra:      proximoEstado = estEspera;
      // A press takes priority over a timeout that occurs in the same cycle.
      estEspera: begin
        if      (jogada_feita) proximoEstado = estRegistra;
        else if (timeoutCond)  proximoEstado = estFimTimeout;
        else                   proximoEstado = estEspera;
      end
      estRegistra:       proximoEstado = estCompara;
      estCompara: begin
        if      (!igual)                proximoEstado = estFimErrou;
        else if (!fimRodada)            proximoEstado = estProximaJogada;
        else if (fimTotal)              proximoEstado = estFimAcertou;
        else                            proximoEstado = estAvancaEscrita;
      end
      estProximaJogada:  proximoEstado = estEspera;
      estAvancaEscrita:  proximoEstado = estEsperaEscrita;
      estEsperaEscrita: begin
        if      (jogada_feita) proximoEstado = estEscreveJogada;
        else if (timeoutCond)  proximoEstado = estFimTimeout;
        else                   proximoEstado = estEsperaEscrita;
      end
      estEscreveJogada:  proximoEstado = estProximaRodada;
      estProximaRodada:  proximoEstado = estInicioRodada;
      estFimAcertou:     proximoEstado = iniciar ? estPreparacao : estFimAcertou;
      estFimErrou:       proximoEstado = iniciar ? estPreparacao : estFimErrou;
      estFimTimeout:     proximoEstado = iniciar ? estPreparacao : estFimTimeout;
      default:           proximoEstado = estInicial;  // unused codes recover
    endcase
  end

  // Moore output decode
  always_comb begin
    zeraCL            = 1'b0;
    contaCL           = 1'b0;
    registraModo      = 1'b0;
    zeraC             = 1'b0;
    contaC            = 1'b0;
    escreve           = 1'b0;
    zeraR             = 1'b0;
    registraR         = 1'b0;
    contaTimeout      = 1'b0;
    zeraTimeout       = 1'b0;
    contaExibicao     = 1'b0;
    zeraExibicao      = 1'b0;
    resetEdgeDetector = 1'b0;
    seletorLedsBM     = 1'b0;
    mostraLeds        = 1'b0;
    botoes_fixo       = 1'b0;
    pronto            = 1'b0;
    ganhou            = 1'b0;
    perdeu            = 1'b0;
    timeout           = 1'b0;
    unique case (estadoAtual)
      estPreparacao: begin
        zeraCL            = 1'b1;
        zeraC             = 1'b1;
        zeraR             = 1'b1;
        zeraTimeout       = 1'b1;
        zeraExibicao      = 1'b1;
        resetEdgeDetector = 1'b1;
        registraModo      = 1'b1;
      end
      estEscreveInicial: begin
        escreve     = 1'b1;
        botoes_fixo = 1'b1;  // first item is always red
      end
      estInicioRodada: begin
        zeraC        = 1'b1;
        zeraExibicao = 1'b1;
      end
      estMostra: begin
        seletorLedsBM = 1'b1;
        mostraLeds    = 1'b1;
        contaExibicao = 1'b1;
      end
      estProximoMostra: begin
        contaC       = 1'b1;
        zeraExibicao = 1'b1;
      end
      estFimMostra: begin
        zeraC             = 1'b1;
        zeraR             = 1'b1;
        zeraTimeout       = 1'b1;
        resetEdgeDetector = 1'b1;
      end
      estEspera, estEsperaEscrita: begin
        mostraLeds   = 1'b1;
        contaTimeout = TimeoutEn;
      end
      estRegistra:      registraR = 1'b1;
      estProximaJogada: begin
        contaC      = 1'b1;
        zeraTimeout = 1'b1;
      end
      estAvancaEscrita: begin
        contaC            = 1'b1;
        zeraTimeout       = 1'b1;
        resetEdgeDetector = 1'b1;
      end
      estEscreveJogada: escreve = 1'b1;  // held buttons are the write source
      estProximaRodada: contaCL = 1'b1;
      estFimAcertou: begin
        pronto = 1'b1;
        ganhou = 1'b1;
      end
      estFimErrou: begin
        pronto = 1'b1;
        perdeu = 1'b1;
      end
      estFimTimeout: begin
        pronto  = 1'b1;
        timeout = 1'b1;
      end
      default: ;
    endcase
  end

  assign db_estado = estadoAtual;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// -----------------------------------------------------------------------------
// tb_unidade_controle_jogo
//
// Directed-vector bench for unidade_controle_jogo. It walks the game through
// the following scenarios:
//   - reset in the middle of a round
//   - a full round 0 with an append
//   - a wrong press in round 1
//   - a winning last compare
//   - timeout behaviour, which depends on CONTROLE_TIMEOUT_EN
// Expected state codes and output sets are written by hand from the state
// table.
// -----------------------------------------------------------------------------
module tb_unidade_controle_jogo;

`ifdef CONTROLE_TIMEOUT_EN
  localparam logic TimeoutEn = 1'b1;
`else
  localparam logic TimeoutEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset, iniciar, fimRodada, fimTotal, igual, jogada_feita;
  logic fimExibicao, fimTimeout, configTimeout_reg;
  logic zeraCL, contaCL, registraModo, zeraC, contaC, escreve, zeraR, registraR;
  logic contaTimeout, zeraTimeout, contaExibicao, zeraExibicao, resetEdgeDetector;
  logic seletorLedsBM, mostraLeds, botoes_fixo, pronto, ganhou, perdeu, timeout;
  logic [4:0] db_estado;

  int nChecks = 0;
  int nFails  = 0;

  typedef struct packed {
    logic zeraCL, contaCL, registraModo, zeraC, contaC, escreve, zeraR, registraR;
    logic contaTimeout, zeraTimeout, contaExibicao, zeraExibicao, resetEdgeDetector;
    logic seletorLedsBM, mostraLeds, botoes_fixo, pronto, ganhou, perdeu, timeout;
  } saidas_t;

  saidas_t saidas;
  assign saidas = '{zeraCL, contaCL, registraModo, zeraC, contaC, escreve, zeraR,
                    registraR, contaTimeout, zeraTimeout, contaExibicao, zeraExibicao,
                    resetEdgeDetector, seletorLedsBM, mostraLeds, botoes_fixo,
                    pronto, ganhou, perdeu, timeout};

  unidade_controle_jogo dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .fimRodada(fimRodada),
    .fimTotal(fimTotal), .igual(igual), .jogada_feita(jogada_feita),
    .fimExibicao(fimExibicao), .fimTimeout(fimTimeout),
    .configTimeout_reg(configTimeout_reg),
    .zeraCL(zeraCL), .contaCL(contaCL), .registraModo(registraModo),
    .zeraC(zeraC), .contaC(contaC), .escreve(escreve), .zeraR(zeraR),
    .registraR(registraR), .contaTimeout(contaTimeout), .zeraTimeout(zeraTimeout),
    .contaExibicao(contaExibicao), .zeraExibicao(zeraExibicao),
    .resetEdgeDetector(resetEdgeDetector), .seletorLedsBM(seletorLedsBM),
    .mostraLeds(mostraLeds), .botoes_fixo(botoes_fixo), .pronto(pronto),
    .ganhou(ganhou), .perdeu(perdeu), .timeout(timeout), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Hand-written expected output set for each state code.
  function automatic saidas_t esperado(input logic [4:0] s);
    saidas_t o;
    o = '0;
    case (s)
      5'h01: begin
        o.zeraCL = 1'b1; o.zeraC = 1'b1; o.zeraR = 1'b1; o.zeraTimeout = 1'b1;
        o.zeraExibicao = 1'b1; o.resetEdgeDetector = 1'b1; o.registraModo = 1'b1;
      end
      5'h02: begin o.escreve = 1'b1; o.botoes_fixo = 1'b1; end
      5'h03: begin o.zeraC = 1'b1; o.zeraExibicao = 1'b1; end
      5'h04: begin o.seletorLedsBM = 1'b1; o.mostraLeds = 1'b1; o.contaExibicao = 1'b1; end
      5'h05: begin o.contaC = 1'b1; o.zeraExibicao = 1'b1; end
      5'h06: begin
        o.zeraC = 1'b1; o.zeraR = 1'b1; o.zeraTimeout = 1'b1; o.resetEdgeDetector = 1'b1;
      end
      5'h07, 5'h0C: begin o.mostraLeds = 1'b1; o.contaTimeout = TimeoutEn; end
      5'h08: o.registraR = 1'b1;
      5'h0A: begin o.contaC = 1'b1; o.zeraTimeout = 1'b1; end
      5'h0B: begin o.contaC = 1'b1; o.zeraTimeout = 1'b1; o.resetEdgeDetector = 1'b1; end
      5'h0D: o.escreve = 1'b1;
      5'h0E: o.contaCL = 1'b1;
      5'h10: begin o.pronto = 1'b1; o.ganhou = 1'b1; end
      5'h11: begin o.pronto = 1'b1; o.perdeu = 1'b1; end
      5'h12: begin o.pronto = 1'b1; o.timeout = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obtido,
                       input logic [31:0] esperadoVal);
    nChecks++;
    if (obtido !== esperadoVal) begin
      nFails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obtido, esperadoVal);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expectState(input string tag, input logic [4:0] st);
    check({tag, "_estado"}, {27'd0, db_estado}, {27'd0, st});
    check({tag, "_saidas"}, {12'd0, saidas}, {12'd0, esperado(st)});
  endtask

  // Starting from 01, reach 07 with a single-item display.
  task automatic startToEspera(input string tag);
    step(); expectState({tag, "_02"}, 5'h02);
    step(); expectState({tag, "_03"}, 5'h03);
    step(); expectState({tag, "_04"}, 5'h04);
    fimExibicao = 1'b1; fimRodada = 1'b1;
    step(); expectState({tag, "_06"}, 5'h06);
    fimExibicao = 1'b0;
    step(); expectState({tag, "_07"}, 5'h07);
  endtask

  initial begin
    reset = 1'b1; iniciar = 1'b0; fimRodada = 1'b0; fimTotal = 1'b0; igual = 1'b0;
    jogada_feita = 1'b0; fimExibicao = 1'b0; fimTimeout = 1'b0; configTimeout_reg = 1'b0;
    step(2);
    reset = 1'b0;
    step(); expectState("pos_reset", 5'h00);

    // Reach 07, then reset mid-round.
    iniciar = 1'b1;
    step(); expectState("ini_01", 5'h01);
    iniciar = 1'b0;
    step(); expectState("ini_02", 5'h02);
    step(); expectState("ini_03", 5'h03);
    step(); expectState("ini_04", 5'h04);
    step(3); expectState("mostra_hold", 5'h04);
    fimExibicao = 1'b1; fimRodada = 1'b1;
    step(); expectState("ini_06", 5'h06);
    fimExibicao = 1'b0;
    step(); expectState("ini_07", 5'h07);
    reset = 1'b1;
    step(); expectState("reset_em_07", 5'h00);
    reset = 1'b0;
    step(); expectState("apos_reset_07", 5'h00);

    // Round 0: correct red press, then append green.
    iniciar = 1'b1;
    step(); expectState("r0_01", 5'h01);
    iniciar = 1'b0;
    startToEspera("r0");
    step(); expectState("r0_espera", 5'h07);
    jogada_feita = 1'b1; igual = 1'b1; fimRodada = 1'b1; fimTotal = 1'b0;
    step(); expectState("r0_08", 5'h08);
    jogada_feita = 1'b0;
    step(); expectState("r0_09", 5'h09);
    step(); expectState("r0_0B", 5'h0B);
    step(); expectState("r0_0C", 5'h0C);
    step(); expectState("r0_0C_hold", 5'h0C);
    jogada_feita = 1'b1;
    step(); expectState("r0_0D", 5'h0D);
    jogada_feita = 1'b0;
    step(); expectState("r0_0E", 5'h0E);
    step(); expectState("r0_03", 5'h03);

    // Round 1: show two items, first press right, second wrong.
    step(); expectState("r1_04a", 5'h04);
    fimExibicao = 1'b1; fimRodada = 1'b0;
    step(); expectState("r1_05", 5'h05);
    fimExibicao = 1'b0;
    step(); expectState("r1_04b", 5'h04);
    fimExibicao = 1'b1; fimRodada = 1'b1;
    step(); expectState("r1_06", 5'h06);
    fimExibicao = 1'b0;
    step(); expectState("r1_07", 5'h07);
    jogada_feita = 1'b1; igual = 1'b1; fimRodada = 1'b0;
    step(); expectState("r1_08a", 5'h08);
    jogada_feita = 1'b0;
    step(); expectState("r1_09a", 5'h09);
    step(); expectState("r1_0A", 5'h0A);
    step(); expectState("r1_07b", 5'h07);
    jogada_feita = 1'b1; igual = 1'b0; fimRodada = 1'b1;
    step(); expectState("r1_08b", 5'h08);
    jogada_feita = 1'b0;
    step(); expectState("r1_09b", 5'h09);
    step(); expectState("errou", 5'h11);
    step(3); expectState("errou_hold", 5'h11);
    iniciar = 1'b1;
    step(); expectState("errou_restart", 5'h01);
    iniciar = 1'b0;

    // Last compare of the game: win, with no further write.
    startToEspera("win");
    jogada_feita = 1'b1; igual = 1'b1; fimRodada = 1'b1; fimTotal = 1'b1;
    step(); expectState("win_08", 5'h08);
    jogada_feita = 1'b0;
    step(); expectState("win_09", 5'h09);
    step(); expectState("acertou", 5'h10);
    step(2); expectState("acertou_hold", 5'h10);
    iniciar = 1'b1;
    step(); expectState("acertou_restart", 5'h01);
    iniciar = 1'b0; fimTotal = 1'b0;

    // Timeout behaviour.
    startToEspera("to");
    fimTimeout = 1'b1; configTimeout_reg = 1'b0;
    step(3); expectState("to_cfg_off", 5'h07);
    configTimeout_reg = 1'b1; jogada_feita = 1'b1; igual = 1'b1; fimRodada = 1'b0;
    step(); expectState("to_jogada_vence", 5'h08);
    jogada_feita = 1'b0;
    step(); expectState("to_09", 5'h09);
    step(); expectState("to_0A", 5'h0A);
    step(); // 0A -> 07; in 07 the timeout condition is already present
    if (TimeoutEn) begin
      expectState("to_07", 5'h07);
      step(); expectState("fim_timeout", 5'h12);
      step(2); expectState("fim_timeout_hold", 5'h12);
    end else begin
      int desvios;
      desvios = 0;
      expectState("to_07", 5'h07);
      for (int i = 0; i < 10000; i++) begin
        step();
        if (db_estado !== 5'h07 || contaTimeout !== 1'b0 || timeout !== 1'b0)
          desvios++;
      end
      check("to_desligado_10000", desvios, 0);
    end
    fimTimeout = 1'b0; configTimeout_reg = 1'b0;
    reset = 1'b1;
    step(); expectState("reset_final", 5'h00);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
